// File: rtl/mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mul_arbiter
// Purpose  : Round-robin arbiter sharing one registered multiplier among
//            NUM_REQ requesters, with a backpressured response channel.
// Revision : 1.0 - initial release
// ============================================================================
module mul_arbiter #(
    parameter int IS_DOUBLE   = 0,
    parameter int TOTAL_WIDTH = (IS_DOUBLE != 0) ? 64 : 32,
    parameter int NUM_REQ     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*TOTAL_WIDTH-1:0] req_op1,
    input  logic [NUM_REQ*TOTAL_WIDTH-1:0] req_op2,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [TOTAL_WIDTH-1:0]         mul_op1,
    output logic [TOTAL_WIDTH-1:0]         mul_op2,
    input  logic [TOTAL_WIDTH-1:0]         mul_result,
    output logic                           resp_valid,
    output logic [2:0]                     resp_id,
    output logic [TOTAL_WIDTH-1:0]         resp_result,
    input  logic                           resp_ready,
    output logic                           busy,
    output logic [15:0]                    op_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] LAST_RST = 3'(NUM_REQ - 1);

    state_t                   state_q, state_d;
    logic [2:0]               last_grant_q, last_grant_d;
    logic [2:0]               id_q, id_d;
    logic [2:0]               resp_id_q, resp_id_d;
    logic [TOTAL_WIDTH-1:0]   op1_q, op1_d, op2_q, op2_d;
    logic [TOTAL_WIDTH-1:0]   result_q, result_d;
    logic [15:0]              op_count_q, op_count_d;

    logic [7:0]               valid_ext;
    logic [7:0]               grant_ext;
    logic [2:0]               winner;
    logic                     found;
    logic [3:0]               cand;
    logic                     handshake;
    logic [TOTAL_WIDTH-1:0]   op1_arr [8];
    logic [TOTAL_WIDTH-1:0]   op2_arr [8];

    // Pad the requester set to 8 so every 3-bit index is in range.
    assign valid_ext = 8'(req_valid);

    for (genvar i = 0; i < 8; i++) begin : g_slice
        if (i < NUM_REQ) begin : g_used
            assign op1_arr[i] = req_op1[i*TOTAL_WIDTH +: TOTAL_WIDTH];
            assign op2_arr[i] = req_op2[i*TOTAL_WIDTH +: TOTAL_WIDTH];
        end else begin : g_pad
            assign op1_arr[i] = '0;
            assign op2_arr[i] = '0;
        end
    end

    // Search starts just after the last granted requester and wraps.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant_q} + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (!found && valid_ext[cand[2:0]]) begin
                found  = 1'b1;
                winner = cand[2:0];
            end
        end
    end

    always_comb begin
        grant_ext = 8'd1 << winner;
        req_ready = '0;
        if (!rst && state_q == S_IDLE && found) begin
            req_ready = grant_ext[NUM_REQ-1:0];
        end
    end

    assign handshake = |(req_valid & req_ready);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        resp_id_d    = resp_id_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        result_d     = result_q;
        op_count_d   = op_count_q;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    state_d      = S_ISSUE;
                    last_grant_d = winner;
                    id_d         = winner;
                    op1_d        = op1_arr[winner];
                    op2_d        = op2_arr[winner];
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                state_d   = S_RESP;
                result_d  = mul_result;
                resp_id_d = id_q;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d    = S_IDLE;
                    op_count_d = op_count_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= LAST_RST;
            id_q         <= '0;
            resp_id_q    <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            result_q     <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            resp_id_q    <= resp_id_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            result_q     <= result_d;
            op_count_q   <= op_count_d;
        end
    end

    assign mul_op1     = op1_q;
    assign mul_op2     = op2_q;
    assign resp_valid  = (state_q == S_RESP);
    assign resp_id     = resp_id_q;
    assign resp_result = result_q;
    assign busy        = (state_q != S_IDLE);
    assign op_count    = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_arbiter
// Purpose  : Directed self-checking bench for mul_arbiter with a stub
//            registered multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_op1 = '0;
    logic [127:0] req_op2 = '0;
    logic [3:0]   req_ready;
    logic [31:0]  mul_op1, mul_op2;
    logic [31:0]  mul_result = '0;
    logic         resp_valid;
    logic [2:0]   resp_id;
    logic [31:0]  resp_result;
    logic         resp_ready = 1'b0;
    logic         busy;
    logic [15:0]  op_count;

    int total = 0;
    int bad   = 0;

    mul_arbiter #(.IS_DOUBLE(0), .TOTAL_WIDTH(32), .NUM_REQ(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op1(req_op1), .req_op2(req_op2),
        .req_ready(req_ready),
        .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_result(mul_result),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
        .resp_ready(resp_ready), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Known binary32 products for the directed vectors; anything else gets a
    // distinct deterministic pattern.
    function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3FC00000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h7F800000 && b == 32'h00000000) return 32'h7FC00000;
        return a ^ {b[15:0], b[31:16]};
    endfunction

    always @(posedge clk) mul_result <= mul_model(mul_op1, mul_op2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_op1[i*32 +: 32] = a;
        req_op2[i*32 +: 32] = b;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; resp_ready = 1'b0;
        #3;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
        total++; if (mul_op1 !== 32'h0 || mul_op2 !== 32'h0) begin bad++; $display("FAIL rst_mul_op: got %h %h want 0 0", mul_op1, mul_op2); end
        total++; if (resp_valid !== 1'b0 || resp_id !== 3'd0 || resp_result !== 32'h0) begin bad++; $display("FAIL rst_resp: got %b %0d %h want 0 0 0", resp_valid, resp_id, resp_result); end
        total++; if (busy !== 1'b0 || op_count !== 16'h0) begin bad++; $display("FAIL rst_status: got busy=%b cnt=%h want 0 0", busy, op_count); end
        tick();
        req_valid = 4'h0;
    endtask

    task automatic test_single();
        set_ops(2, 32'h3FC00000, 32'h40000000);
        @(negedge clk);
        rst = 1'b0; req_valid = 4'b0100; resp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b want 0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        total++; if (busy !== 1'b1 || mul_op1 !== 32'h3FC00000 || mul_op2 !== 32'h40000000) begin bad++; $display("FAIL single_issue: got busy=%b %h %h want 1 3fc00000 40000000", busy, mul_op1, mul_op2); end
        tick();
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL single_wait_valid: got %b want 0", resp_valid); end
        tick();
        total++; if (resp_valid !== 1'b1 || resp_id !== 3'd2 || resp_result !== 32'h40400000) begin bad++; $display("FAIL single_resp: got %b %0d %h want 1 2 40400000", resp_valid, resp_id, resp_result); end
        tick();
        total++; if (resp_valid !== 1'b0 || op_count !== 16'd1 || busy !== 1'b0) begin bad++; $display("FAIL single_done: got v=%b cnt=%0d busy=%b want 0 1 0", resp_valid, op_count, busy); end
        tick(); tick();
        total++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin bad++; $display("FAIL idle_hold: got busy=%b rdy=%b want 0 0000", busy, req_ready); end
    endtask

    task automatic test_contention();
        for (int i = 0; i < 4; i++) set_ops(i, 32'h40000000 + i, 32'h3F800000 + (i << 8));
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0; req_valid = 4'hF; resp_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            logic [3:0]  exp_g;
            logic [31:0] exp_r;
            exp_g = 4'b0001 << (r % 4);
            exp_r = mul_model(32'h40000000 + (r % 4), 32'h3F800000 + ((r % 4) << 8));
            #1;
            total++; if (req_ready !== exp_g) begin bad++; $display("FAIL cont_grant%0d: got %b want %b", r, req_ready, exp_g); end
            tick();
            total++; if (req_ready !== 4'b0000 || resp_valid !== 1'b0) begin bad++; $display("FAIL cont_issue%0d: got rdy=%b v=%b want 0000 0", r, req_ready, resp_valid); end
            tick();
            tick();
            total++; if (resp_valid !== 1'b1 || resp_id !== 3'(r % 4) || resp_result !== exp_r) begin bad++; $display("FAIL cont_resp%0d: got %b %0d %h want 1 %0d %h", r, resp_valid, resp_id, resp_result, r % 4, exp_r); end
            tick();
        end
        total++; if (op_count !== 16'd5) begin bad++; $display("FAIL cont_count: got %0d want 5", op_count); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_r;
        exp_r = mul_model(32'h40000001, 32'h3F800100);
        req_valid = 4'b1010; resp_ready = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
        tick(); tick(); tick();
        for (int c = 0; c < 10; c++) begin
            total++; if (resp_valid !== 1'b1 || resp_id !== 3'd1 || resp_result !== exp_r || req_ready !== 4'b0000) begin bad++; $display("FAIL bp_hold%0d: got v=%b id=%0d res=%h rdy=%b want 1 1 %h 0000", c, resp_valid, resp_id, resp_result, req_ready, exp_r); end
            tick();
        end
        resp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0000 || resp_valid !== 1'b1) begin bad++; $display("FAIL bp_release_cycle: got rdy=%b v=%b want 0000 1", req_ready, resp_valid); end
        tick();
        total++; if (resp_valid !== 1'b0 || op_count !== 16'd6) begin bad++; $display("FAIL bp_release: got v=%b cnt=%0d want 0 6", resp_valid, op_count); end
        #1;
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_next_grant: got %b want 1000", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick(); tick();
        total++; if (resp_valid !== 1'b1 || resp_id !== 3'd3) begin bad++; $display("FAIL bp_next_resp: got %b %0d want 1 3", resp_valid, resp_id); end
        tick();
    endtask

    task automatic test_reset_midop();
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        tick();
        total++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL midop_wait: got busy=%b v=%b want 1 0", busy, resp_valid); end
        #2;
        rst = 1'b1; req_valid = 4'b0010;
        #1;
        total++; if (busy !== 1'b0 || resp_valid !== 1'b0 || op_count !== 16'd0 || mul_op1 !== 32'h0 || mul_op2 !== 32'h0 || resp_result !== 32'h0 || resp_id !== 3'd0 || req_ready !== 4'b0000) begin bad++; $display("FAIL midop_async: got busy=%b v=%b cnt=%0d op=%h/%h res=%h id=%0d rdy=%b want all 0", busy, resp_valid, op_count, mul_op1, mul_op2, resp_result, resp_id, req_ready); end
        tick();
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL midop_first_grant: got %b want 0010", req_ready); end
        tick();
        req_valid = 4'b0000;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL midop_no_stale: got %b want 0", resp_valid); end
        tick(); tick();
        total++; if (resp_valid !== 1'b1 || resp_id !== 3'd1 || resp_result !== mul_model(32'h40000001, 32'h3F800100) || op_count !== 16'd0) begin bad++; $display("FAIL midop_resp: got %b %0d %h cnt=%0d want 1 1 model 0", resp_valid, resp_id, resp_result, op_count); end
        tick();
        total++; if (op_count !== 16'd1) begin bad++; $display("FAIL midop_count: got %0d want 1", op_count); end
    endtask

    task automatic test_special();
        set_ops(0, 32'h7F800000, 32'h00000000);
        req_valid = 4'b0001;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL nan_grant: got %b want 0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick(); tick();
        total++; if (resp_valid !== 1'b1 || resp_id !== 3'd0 || resp_result !== 32'h7FC00000) begin bad++; $display("FAIL nan_resp: got %b %0d %h want 1 0 7fc00000", resp_valid, resp_id, resp_result); end
        tick();
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.op_count_q = 16'hFFFF;
        #1;
        release dut.op_count_q;
        tick();
        total++; if (op_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload: got %h want ffff", op_count); end
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0000;
        tick(); tick();
        total++; if (resp_valid !== 1'b1 || op_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_resp: got v=%b cnt=%h want 1 ffff", resp_valid, op_count); end
        tick();
        total++; if (op_count !== 16'h0000 || resp_valid !== 1'b0) begin bad++; $display("FAIL wrap_count: got %h v=%b want 0000 0", op_count, resp_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_midop();
        test_special();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter: IS_DOUBLE, default 0, selects the binary32 (0) or binary64 (1) operand format.
REQ-002 Parameter: TOTAL_WIDTH, default 32 when IS_DOUBLE=0 and 64 when IS_DOUBLE=1, is the operand and result width.
REQ-003 Parameter: NUM_REQ, default 4, range 2..8, is the number of requesters.
REQ-004 Port: clk  in  1  is the single clock; all state changes occur on its rising edge.
REQ-005 Port: rst  in  1  is the reset; it is asynchronous and active-high.
REQ-006 Port: req_valid  in  NUM_REQ  carries one request-valid bit per requester.
REQ-007 Port: req_op1, req_op2  in  NUM_REQ*TOTAL_WIDTH  carry the operands; requester i uses slice [i*TOTAL_WIDTH +: TOTAL_WIDTH].
REQ-008 Port: req_ready  out  NUM_REQ  is one-hot or zero and marks the granted requester.
REQ-009 Port: mul_op1, mul_op2  out  TOTAL_WIDTH  are registered operands driven to the shared real_mul.
REQ-010 Port: mul_result  in  TOTAL_WIDTH  is the registered real_mul output (1-cycle latency).
REQ-011 Port: resp_valid  out  1, resp_id  out  3, resp_result  out  TOTAL_WIDTH  form the response channel.
REQ-012 Port: resp_ready  in  1  is consumer backpressure.
REQ-013 Port: busy  out  1  is high in any state other than IDLE.
REQ-014 Port: op_count  out  16  counts completed responses and wraps from 0xFFFF to 0.

Function
REQ-015 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-016 In IDLE, req_ready SHALL be combinational: high only for the round-robin winner among the set req_valid bits, and all zero in every other state.
REQ-017 Round-robin search SHALL start at last_grant+1 mod NUM_REQ; last_grant SHALL update only on a handshake (req_valid[i] & req_ready[i]).
REQ-018 On a handshake edge, the block SHALL register the winner's operands into mul_op1/mul_op2, store the winner index, and go IDLE->ISSUE.
REQ-019 mul_op1/mul_op2 SHALL change only on a handshake and otherwise hold their last value.
REQ-020 ISSUE->WAIT SHALL occur unconditionally after one cycle, during which real_mul samples its operands.
REQ-021 WAIT->RESP SHALL occur unconditionally, capturing mul_result into resp_result and the stored index into resp_id on that edge.
REQ-022 resp_valid SHALL be high exactly in RESP; resp_result and resp_id SHALL stay stable while resp_valid=1 and resp_ready=0.
REQ-023 RESP->IDLE SHALL occur on an edge with resp_ready=1, and op_count SHALL increment on that same edge.
REQ-024 Grant-to-response latency: handshake in cycle 0 -> resp_valid first high in cycle 3; peak throughput is one operation per 4 cycles.
REQ-025 No grant SHALL occur in the cycle RESP is left; the earliest next handshake is the following IDLE cycle.
REQ-026 A requester dropping req_valid while not granted SHALL lose nothing; requests are not queued internally.
REQ-027 With no req_valid set, the FSM SHALL remain in IDLE and last_grant SHALL be unchanged.

Reset
REQ-028 While rst=1, asynchronously: state=IDLE, last_grant=NUM_REQ-1 (requester 0 highest priority), all outputs 0 including mul_op1/mul_op2, resp_result, resp_id and op_count.
REQ-029 A reset mid-operation (ISSUE/WAIT/RESP) SHALL discard the in-flight operation with no response produced.
REQ-030 After rst deasserts, the first handshake SHALL be possible on the first rising edge.

Verification
REQ-031 Single request: req 2 sends 0x3FC00000 x 0x40000000 (binary32), resp_ready=1 -> resp_valid in cycle 3 with resp_id=2, resp_result=0x40400000, op_count=1.
REQ-032 Contention: all 4 requesters valid continuously after reset -> grant order 0,1,2,3,0, each response 4 cycles apart.
REQ-033 Backpressure: resp_ready held 0 for 10 cycles in RESP -> resp_valid, resp_id and resp_result stay constant, req_ready stays 0, then the next grant follows one cycle after release.
REQ-034 Reset mid-op: rst pulse during WAIT -> outputs 0 immediately, no resp_valid, and a later request to req 1 completes normally.
REQ-035 Wrap: op_count preloaded via 65535 completions -> the next completion yields op_count=0.
REQ-036 Special operand: req 0 sends 0x7F800000 x 0x00000000 -> resp_result equals real_mul output 0x7FC00000 (NaN) with resp_id=0.
